pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register carrying a data payload plus a control bundle between two processor pipeline stages (ID/EX, EX/MEM, MEM/WB). It replaces the fixed-width always-load stage registers with a valid/ready handshake, stall (back-pressure) support, synchronous flush for bubble insertion, and an optional skid entry that keeps full throughput without a combinational ready path. An empty or flushed stage always presents the configured NOP control word downstream.

## Interface
Parameters:
- DATA_W, 64: payload width (operands, immediate, register indices, PC).
- CTRL_W, 12: control bundle width (RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[4:0]).
- CTRL_NOP, 12'h01F: control value presented when the stage holds no valid entry (all enables 0, ALUOp 5'b11111).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous discard of all held entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage accepts an entry this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control bundle.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  presented payload.
- out_ctrl  out  CTRL_W  presented control bundle.
- occupancy  out  2  number of held entries (0..2).

## Operation
- Input transfer: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready.
- Storage: main entry M drives out_*; skid entry S (only with PIPE_SKID_EN) holds one extra entry.
- Reset (rst low, async): out_valid=0, out_data=0, out_ctrl=CTRL_NOP, S empty, occupancy=0, in_ready=1.
- Priority per edge: flush > output transfer > input transfer.
- Flush: M and S invalidated; out_data=0, out_ctrl=CTRL_NOP; any input transfer in the same cycle is discarded; in_ready=1 next cycle.
- M empty or output transfer this cycle: M loads S if S valid, else the incoming entry; if neither, M becomes empty (bubble: out_data=0, out_ctrl=CTRL_NOP).
- M full, no output transfer, input transfer: entry goes to S.
- S valid and output transfer with concurrent input transfer cannot occur (in_ready=0 while S valid).
- Order strictly FIFO; no entry is duplicated or dropped except by flush.
- out_data/out_ctrl stable while out_valid && !out_ready.

## Timing
- Latency: 1 cycle from input transfer to out_valid when empty.
- Throughput: one entry per cycle under continuous out_ready=1.
- Skid mode: in_ready registered, in_ready = !S_valid; deasserts the cycle after S fills, reasserts the cycle after S drains into M.
- Non-skid mode: in_ready = !out_valid || out_ready (combinational from out_ready).
- occupancy updates on the same edge as the transfers it reflects.
- Reset deasserted mid-operation: state restarts empty; first acceptance on the first edge after release.

## Configuration
- PIPE_SKID_EN defined: two-entry stage, registered in_ready, max occupancy 2.
- PIPE_SKID_EN undefined: single-entry stage, combinational in_ready, occupancy never exceeds 1, S logic absent.

## Structure
- Shared package pipe_pkg: control-bundle field offsets, ALUOP_NOP (5'b11111), default CTRL_NOP, per-stage DATA_W constants.
- Sub-module pipe_skid_buf: S entry storage and in_ready generation, instantiated only under PIPE_SKID_EN.

## Test plan
- Reset: rst low with occupancy 2 -> immediately out_valid=0, out_ctrl=12'h01F, out_data=0, occupancy=0, in_ready=1.
- Streaming: in_valid=1, out_ready=1, data 1..8 -> out_data 1..8 on consecutive cycles, one-cycle latency, no gaps.
- Back-pressure (skid): out_ready=0, send A,B,C -> A in M, B in S, in_ready=0, C held; out_ready=1 -> A,B,C in order, occupancy 2,1,1,0.
- Flush: occupancy 2 plus concurrent input D, flush=1 -> next cycle out_valid=0, out_ctrl=NOP, occupancy 0; D never emitted.
- Replace-on-drain: M holds X, out_ready=1, in_valid=1 with Y -> next cycle out_data=Y, occupancy 1.
- Non-skid build: M full, out_ready=0 -> in_ready=0 same cycle; out_ready=1 -> in_ready=1 same cycle, back-to-back transfers.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared control-bundle layout, NOP word and per-stage widths
// for the pipe_stage_reg pipeline registers.
package pipe_pkg;

    localparam int unsigned CTRL_W_DEF = 12;

    localparam int unsigned ALUOP_LSB    = 0;
    localparam int unsigned ALUOP_W      = 5;
    localparam int unsigned BRANCH_BIT   = 5;
    localparam int unsigned MEMWRITE_BIT = 6;
    localparam int unsigned MEMREAD_BIT  = 7;
    localparam int unsigned REGWRITE_BIT = 8;
    localparam int unsigned MEMTOREG_BIT = 9;
    localparam int unsigned ALUSRC_BIT   = 10;
    localparam int unsigned REGDST_BIT   = 11;

    localparam logic [ALUOP_W-1:0] ALUOP_NOP = 5'b11111;

    // All enables low, ALUOp parked on its NOP encoding.
    localparam logic [CTRL_W_DEF-1:0] CTRL_NOP_DEF = {7'b0, ALUOP_NOP};

    localparam int unsigned ID_EX_DATA_W  = 64;
    localparam int unsigned EX_MEM_DATA_W = 64;
    localparam int unsigned MEM_WB_DATA_W = 64;

    typedef struct packed {
        logic               reg_dst;
        logic               alu_src;
        logic               mem_to_reg;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               branch;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: one-entry skid storage behind the main stage entry;
// in_ready is taken straight from the skid valid flop.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = ID_EX_DATA_W,
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(CTRL_NOP_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic              drain_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              ready_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (flush_i || drain_i) begin
            valid_d = 1'b0;
            data_d  = '0;
            ctrl_d  = CTRL_NOP;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            ctrl_d  = ctrl_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= CTRL_NOP;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ctrl_o  = ctrl_q;
    assign ready_o = !valid_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with flush and NOP
// bubbles; define PIPE_SKID_EN for the two-entry registered-ready variant.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = ID_EX_DATA_W,
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(CTRL_NOP_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;

    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic [CTRL_W-1:0] s_ctrl;

    logic out_xfer;
    logic in_xfer;
    logic m_take;

    assign out_xfer = m_valid_q && out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign m_take   = !m_valid_q || out_xfer;

`ifdef PIPE_SKID_EN
    logic s_load;
    logic s_drain;

    // S only fills when M is stuck; it drains whenever M frees up.
    assign s_load  = !m_take && in_xfer;
    assign s_drain = m_take && s_valid;

    pipe_skid_buf #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CTRL_NOP (CTRL_NOP)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst),
        .flush_i  (flush),
        .load_i   (s_load),
        .drain_i  (s_drain),
        .data_i   (in_data),
        .ctrl_i   (in_ctrl),
        .valid_o  (s_valid),
        .data_o   (s_data),
        .ctrl_o   (s_ctrl),
        .ready_o  (in_ready)
    );
`else
    assign s_valid  = 1'b0;
    assign s_data   = '0;
    assign s_ctrl   = CTRL_NOP;
    assign in_ready = !m_valid_q || out_ready;
`endif

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_ctrl_d  = m_ctrl_q;
        if (flush) begin
            m_valid_d = 1'b0;
            m_data_d  = '0;
            m_ctrl_d  = CTRL_NOP;
        end else if (m_take) begin
            if (s_valid) begin
                m_valid_d = 1'b1;
                m_data_d  = s_data;
                m_ctrl_d  = s_ctrl;
            end else if (in_xfer) begin
                m_valid_d = 1'b1;
                m_data_d  = in_data;
                m_ctrl_d  = in_ctrl;
            end else begin
                m_valid_d = 1'b0;
                m_data_d  = '0;
                m_ctrl_d  = CTRL_NOP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_ctrl_q  <= CTRL_NOP;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_ctrl_q  <= m_ctrl_d;
        end
    end

    assign out_valid = m_valid_q;
    assign out_data  = m_data_q;
    assign out_ctrl  = m_ctrl_q;
    assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed scoreboard bench for pipe_stage_reg,
// covering both the default and PIPE_SKID_EN builds.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [63:0] d;
        logic [11:0] c;
    } ent_t;

`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    localparam logic [11:0] NOP = 12'h01F;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [11:0] in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [11:0] out_ctrl;
    logic [1:0]  occupancy;

    ent_t q[$];
    ent_t exp_e;
    int   tests = 0;
    int   fails = 0;
    bit   acc;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input bit v, input logic [63:0] d);
        in_valid = v;
        in_data  = d;
        in_ctrl  = 12'h100 | {4'h0, d[7:0]};
    endtask

    // Scoreboard at mid-cycle, then advance past the next rising edge.
    task automatic tick();
        #1;
        acc = 1'b0;
        if (rst && flush) begin
            q.delete();
        end else if (rst) begin
            if (out_valid && out_ready) begin
                tests++;
                assert (q.size() > 0) else begin
                    fails++;
                    $error("FAIL sb_unexpected: observed %0h expected none",
                           out_data);
                end
                if (q.size() > 0) begin
                    exp_e = q.pop_front();
                    chk("sb_data", out_data, exp_e.d);
                    chk("sb_ctrl", {52'h0, out_ctrl}, {52'h0, exp_e.c});
                end
            end
            if (in_valid && in_ready) begin
                q.push_back('{d: in_data, c: in_ctrl});
                acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_valid"}, {63'h0, out_valid}, 64'h0);
        chk({tag, "_data"}, out_data, 64'h0);
        chk({tag, "_ctrl"}, {52'h0, out_ctrl}, {52'h0, NOP});
        chk({tag, "_occ"}, {62'h0, occupancy}, 64'h0);
        chk({tag, "_rdy"}, {63'h0, in_ready}, 64'h1);
    endtask

    logic [63:0] items[3];
    int          idx;
    logic [1:0]  occ_exp[3];
    int          budget;

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 64'h0);
        tick();
        tick();
        chk_empty("reset");
        rst = 1'b1;

        // streaming 1..8
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 64'(i));
            tick();
            chk("stream_valid", {63'h0, out_valid}, 64'h1);
            chk("stream_data", out_data, 64'(i));
        end
        drive(1'b0, 64'h0);
        tick();
        chk_empty("bubble");

        // back-pressure A,B,C
        items[0] = 64'hA;
        items[1] = 64'hB;
        items[2] = 64'hC;
        idx = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, items[idx]);
            tick();
            if (acc) idx++;
            if (k == 0)
                chk("bp_rdy_m_full", {63'h0, in_ready}, {63'h0, SKID});
        end
        chk("bp_occ_full", {62'h0, occupancy}, SKID ? 64'h2 : 64'h1);
        chk("bp_rdy_full", {63'h0, in_ready}, 64'h0);
        chk("bp_hold_data", out_data, 64'hA);
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_release", {63'h0, in_ready}, {63'h0, !SKID});
        occ_exp[0] = 2'd1;
        occ_exp[1] = 2'd1;
        occ_exp[2] = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (idx < 3) drive(1'b1, items[idx]);
            else drive(1'b0, 64'h0);
            tick();
            if (acc) idx++;
            chk("bp_occ_drain", {62'h0, occupancy}, {62'h0, occ_exp[k]});
        end
        chk("bp_all_sent", 64'(idx), 64'd3);

        // flush with concurrent input D
        out_ready = 1'b0;
        drive(1'b1, 64'hE);
        tick();
        drive(1'b1, 64'hF);
        tick();
        chk("fl_occ_full", {62'h0, occupancy}, SKID ? 64'h2 : 64'h1);
        flush = 1'b1;
        drive(1'b1, 64'hD);
        tick();
        flush = 1'b0;
        drive(1'b0, 64'h0);
        chk_empty("flush");
        out_ready = 1'b1;
        tick();
        tick();
        chk("fl_no_d", {63'h0, out_valid}, 64'h0);

        // replace-on-drain X -> Y
        out_ready = 1'b0;
        drive(1'b1, 64'h1111);
        tick();
        out_ready = 1'b1;
        drive(1'b1, 64'h2222);
        tick();
        chk("rod_data", out_data, 64'h2222);
        chk("rod_occ", {62'h0, occupancy}, 64'h1);
        drive(1'b0, 64'h0);
        tick();

        // asynchronous reset while full
        out_ready = 1'b0;
        drive(1'b1, 64'h33);
        tick();
        drive(1'b1, 64'h44);
        tick();
        chk("rst_occ_pre", {62'h0, occupancy}, SKID ? 64'h2 : 64'h1);
        drive(1'b0, 64'h0);
        rst = 1'b0;
        #1;
        chk_empty("midrst");
        q.delete();
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 64'h55);
        tick();
        chk("post_rst_valid", {63'h0, out_valid}, 64'h1);
        chk("post_rst_data", out_data, 64'h55);
        drive(1'b0, 64'h0);

        budget = 0;
        while (q.size() > 0 && budget < 20) begin
            tick();
            budget++;
        end
        chk("sb_drained", 64'(q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
